// File: rtl/maxpool_flatten_pkg.sv
// Shared types and helpers for the CNN pooling front end.
// Holds the pooling FSM state encoding and a signed maximum helper.
package cnn_pkg;

  // Working width of the max helper; callers sign-extend into it and truncate back.
  localparam int SMAX_W = 32;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pool_state_e;

  // Signed maximum of two values at the helper's working width.
  function automatic logic signed [SMAX_W-1:0] smax(
    input logic signed [SMAX_W-1:0] a,
    input logic signed [SMAX_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/maxpool_flatten_if.sv
// Pixel stream in, pooled/flattened vector out, with a frame-level acknowledge.
// master = producer/consumer side (testbench); slave = the pooling block.
interface maxpool_flatten_if #(
  parameter int IP_DATA_WIDTH = 8,
  parameter int NUM_OUT       = 24
);

  logic                            in_valid;
  logic                            in_ready;
  logic signed [IP_DATA_WIDTH-1:0] in_data;
  logic signed [IP_DATA_WIDTH-1:0] x_out [NUM_OUT];
  logic                            x_valid;
  logic                            x_ack;

  modport master (
    output in_valid, in_data, x_ack,
    input  in_ready, x_out, x_valid
  );

  modport slave (
    input  in_valid, in_data, x_ack,
    output in_ready, x_out, x_valid
  );

endinterface

// File: rtl/maxpool_flatten_pool_max2.sv
// Combinational two-input signed maximum at width W (W <= 32).
module pool_max2
  import cnn_pkg::*;
#(
  parameter int W = 8
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] y
);

  // Sign-extend both operands into the helper width, take the max, then narrow back.
  always_comb begin
    y = W'(smax(SMAX_W'(a), SMAX_W'(b)));
  end

endmodule

// File: rtl/maxpool_flatten.sv
// 2x2 stride-2 signed max pooling over a raster-order frame, flattened into
// a vector that is held until the consumer acknowledges it.
module maxpool_flatten
  import cnn_pkg::*;
#(
  parameter int IP_DATA_WIDTH = 8,
  parameter int FMAP_W        = 8,
  parameter int FMAP_H        = 12,
  parameter int NUM_OUT       = (FMAP_W / 2) * (FMAP_H / 2)
) (
  input  logic               clk,
  input  logic               rst,
  maxpool_flatten_if.slave   bus
);

  localparam int HALF_W = FMAP_W / 2;
  localparam int COL_W  = (FMAP_W > 2) ? $clog2(FMAP_W) : 1;
  localparam int ROW_W  = (FMAP_H > 2) ? $clog2(FMAP_H) : 1;
  localparam int LB_IW  = (HALF_W > 1) ? $clog2(HALF_W) : 1;
  localparam int OUT_IW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(FMAP_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FMAP_H - 1);

  if ((FMAP_W < 2) || ((FMAP_W % 2) != 0) ||
      (FMAP_H < 2) || ((FMAP_H % 2) != 0) ||
      (NUM_OUT != (FMAP_W / 2) * (FMAP_H / 2)) ||
      (IP_DATA_WIDTH < 1) || (IP_DATA_WIDTH > SMAX_W)) begin : g_param_check
    $fatal(1, "maxpool_flatten: illegal parameters FMAP_W=%0d FMAP_H=%0d NUM_OUT=%0d IP_DATA_WIDTH=%0d",
           FMAP_W, FMAP_H, NUM_OUT, IP_DATA_WIDTH);
  end

  pool_state_e                     state_q, state_d;
  logic        [COL_W-1:0]         col_q, col_d;
  logic        [ROW_W-1:0]         row_q, row_d;
  logic signed [IP_DATA_WIDTH-1:0] held_q, held_d;
  logic signed [IP_DATA_WIDTH-1:0] linebuf_q [HALF_W];
  logic signed [IP_DATA_WIDTH-1:0] linebuf_d [HALF_W];
  logic signed [IP_DATA_WIDTH-1:0] x_out_q [NUM_OUT];
  logic signed [IP_DATA_WIDTH-1:0] x_out_d [NUM_OUT];

  logic        [LB_IW-1:0]         lb_idx;
  logic        [OUT_IW-1:0]        out_idx;
  logic signed [IP_DATA_WIDTH-1:0] lb_rd;
  logic signed [IP_DATA_WIDTH-1:0] pair_max;
  logic signed [IP_DATA_WIDTH-1:0] quad_max;
  logic                            accept;

  assign bus.in_ready = (state_q == FILL) && !rst;
  assign bus.x_valid  = (state_q == HOLD);
  assign bus.x_out    = x_out_q;
  assign accept       = bus.in_valid && bus.in_ready;

  // Map the current pixel position onto its line-buffer slot and pooled output slot.
  always_comb begin
    lb_idx  = LB_IW'(col_q >> 1);
    out_idx = OUT_IW'((row_q >> 1) * HALF_W + (col_q >> 1));
    lb_rd   = linebuf_q[lb_idx];
  end

  // Horizontal pair: the held even-column pixel against the incoming odd-column pixel.
  pool_max2 #(.W(IP_DATA_WIDTH)) u_row_max (
    .a (held_q),
    .b (bus.in_data),
    .y (pair_max)
  );

  // Vertical pair: the upper row's pair maximum against the lower row's pair maximum.
  pool_max2 #(.W(IP_DATA_WIDTH)) u_col_max (
    .a (lb_rd),
    .b (pair_max),
    .y (quad_max)
  );

  // Next-state logic: raster counters, pooling datapath writes and FILL/HOLD control.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    held_d    = held_q;
    linebuf_d = linebuf_q;
    x_out_d   = x_out_q;

    case (state_q)
      FILL: begin
        if (accept) begin
          if (!col_q[0]) begin
            held_d = bus.in_data;
          end else if (!row_q[0]) begin
            linebuf_d[lb_idx] = pair_max;
          end else begin
            x_out_d[out_idx] = quad_max;
          end

          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              row_d   = '0;
              state_d = HOLD;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (bus.x_ack) begin
          state_d = FILL;
          col_d   = '0;
          row_d   = '0;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // State register; reset throws away any partial or pending frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      col_q   <= '0;
      row_q   <= '0;
      held_q  <= '0;
      for (int i = 0; i < HALF_W; i++) begin
        linebuf_q[i] <= '0;
      end
      for (int i = 0; i < NUM_OUT; i++) begin
        x_out_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      held_q    <= held_d;
      linebuf_q <= linebuf_d;
      x_out_q   <= x_out_d;
    end
  end

endmodule

// File: tb/tb_maxpool_flatten.sv
// Scoreboard bench for maxpool_flatten at default parameters (8x12 frame, 24 outputs).
// The driver pushes a hand-derived expected vector per frame; the monitor pops it
// whenever x_valid rises and compares every element.
module tb_maxpool_flatten;

  localparam int DW   = 8;
  localparam int FW   = 8;
  localparam int FH   = 12;
  localparam int NOUT = 24;
  localparam int NPIX = FW * FH;

  typedef logic [NOUT-1:0][DW-1:0] vec_t;

  logic clk;
  logic rst;

  maxpool_flatten_if #(.IP_DATA_WIDTH(DW), .NUM_OUT(NOUT)) bus ();

  maxpool_flatten #(
    .IP_DATA_WIDTH (DW),
    .FMAP_W        (FW),
    .FMAP_H        (FH),
    .NUM_OUT       (NOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic signed [DW-1:0] frame [NPIX];
  vec_t exp_v;
  vec_t zero_v;
  vec_t mon_v;
  vec_t exp_q [$];
  logic prev_valid = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkScalar(input string name, input logic got, input logic want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b, expected %b", name, got, want);
    end
  endtask

  task automatic checkOutput(input string name, input vec_t want);
    for (int i = 0; i < NOUT; i++) begin
      n_cmp++;
      if ($signed(bus.x_out[i]) !== $signed(want[i])) begin
        n_fail++;
        $display("[TB] FAIL %s x_out[%0d]: got %0d, expected %0d",
                 name, i, $signed(bus.x_out[i]), $signed(want[i]));
      end
    end
  endtask

  // Drives npix pixels of frame[] starting at a negedge; optionally idles a cycle between pixels.
  task automatic applyStimulus(input int npix, input bit toggle);
    bit early = 1'b0;
    bit stuck = 1'b0;
    int waitc;
    for (int i = 0; i < npix; i++) begin
      waitc = 0;
      while (!bus.in_ready && waitc < 100) begin
        @(negedge clk);
        waitc++;
      end
      if (!bus.in_ready) begin
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL in_ready_timeout: got in_ready=0 at pixel %0d, expected 1", i);
        stuck = 1'b1;
        break;
      end
      if (bus.x_valid) early = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = frame[i];
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (toggle && (i != npix - 1)) @(negedge clk);
    end
    bus.in_valid = 1'b0;
    if ((npix == NPIX) && !stuck) begin
      checkScalar("early_x_valid", early, 1'b0);
      checkScalar("x_valid_latency", bus.x_valid, 1'b1);
    end
  endtask

  task automatic ackFrame();
    bus.x_ack = 1'b1;
    @(negedge clk);
    bus.x_ack = 1'b0;
    checkScalar("in_ready_after_ack", bus.in_ready, 1'b1);
    checkScalar("x_valid_after_ack", bus.x_valid, 1'b0);
  endtask

  // Monitor: each rising x_valid consumes one expected frame from the scoreboard.
  always @(negedge clk) begin
    if (bus.x_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL unexpected_frame: got x_valid=1, expected no pending frame");
      end else begin
        mon_v = exp_q.pop_front();
        checkOutput("frame", mon_v);
      end
    end
    prev_valid = bus.x_valid;
  end

  initial begin
    #100000;
    n_cmp++;
    n_fail++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t hold_v;
    zero_v       = '0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.x_ack    = 1'b0;

    repeat (3) @(negedge clk);
    $display("[TB] reset state");
    checkScalar("reset_in_ready", bus.in_ready, 1'b0);
    checkScalar("reset_x_valid", bus.x_valid, 1'b0);
    checkOutput("reset_x_out", zero_v);
    rst = 1'b0;
    @(negedge clk);
    checkScalar("in_ready_after_reset", bus.in_ready, 1'b1);

    $display("[TB] ramp frame, back-to-back");
    for (int i = 0; i < NPIX; i++) frame[i] = DW'(i % 128);
    for (int r = 0; r < FH / 2; r++)
      for (int c = 0; c < FW / 2; c++)
        exp_v[r * (FW / 2) + c] = DW'(16 * r + 2 * c + 9);
    exp_q.push_back(exp_v);
    applyStimulus(NPIX, 1'b0);
    ackFrame();

    $display("[TB] negative frame");
    for (int i = 0; i < NPIX; i++) frame[i] = 8'h80;
    frame[9] = -8'sd3;
    for (int i = 0; i < NOUT; i++) exp_v[i] = 8'h80;
    exp_v[0] = 8'hFD;
    exp_q.push_back(exp_v);
    applyStimulus(NPIX, 1'b0);
    ackFrame();

    $display("[TB] ramp frame, in_valid toggling");
    for (int i = 0; i < NPIX; i++) frame[i] = DW'(i % 128);
    for (int r = 0; r < FH / 2; r++)
      for (int c = 0; c < FW / 2; c++)
        exp_v[r * (FW / 2) + c] = DW'(16 * r + 2 * c + 9);
    exp_q.push_back(exp_v);
    applyStimulus(NPIX, 1'b1);
    ackFrame();

    $display("[TB] descending frame held with x_ack low");
    for (int i = 0; i < NPIX; i++) frame[i] = DW'(95 - i);
    for (int r = 0; r < FH / 2; r++)
      for (int c = 0; c < FW / 2; c++)
        hold_v[r * (FW / 2) + c] = DW'(95 - (16 * r + 2 * c));
    exp_q.push_back(hold_v);
    applyStimulus(NPIX, 1'b0);
    for (int k = 0; k < 20; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = DW'(k * 13 - 100);
      @(negedge clk);
      checkScalar("hold_in_ready", bus.in_ready, 1'b0);
    end
    bus.in_valid = 1'b0;
    checkScalar("hold_x_valid", bus.x_valid, 1'b1);
    checkOutput("hold_stable", hold_v);
    ackFrame();

    $display("[TB] mixed-sign frame after hold");
    for (int r = 0; r < FH; r++)
      for (int c = 0; c < FW; c++)
        frame[r * FW + c] = (r % 2 == 0) ? DW'(-(c + 1) * 10) : DW'(c - 50);
    for (int r = 0; r < FH / 2; r++) begin
      exp_v[r * 4 + 0] = DW'(-10);
      exp_v[r * 4 + 1] = DW'(-30);
      exp_v[r * 4 + 2] = DW'(-45);
      exp_v[r * 4 + 3] = DW'(-43);
    end
    exp_q.push_back(exp_v);
    applyStimulus(NPIX, 1'b0);
    ackFrame();

    $display("[TB] reset mid-frame, then constant frame");
    for (int i = 0; i < NPIX; i++) frame[i] = DW'($urandom_range(0, 255));
    applyStimulus(40, 1'b0);
    rst = 1'b1;
    #1;
    checkScalar("midreset_in_ready", bus.in_ready, 1'b0);
    checkScalar("midreset_x_valid", bus.x_valid, 1'b0);
    checkOutput("midreset_x_out", zero_v);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NPIX; i++) frame[i] = DW'(7);
    for (int i = 0; i < NOUT; i++) exp_v[i] = DW'(7);
    exp_q.push_back(exp_v);
    applyStimulus(NPIX, 1'b0);
    ackFrame();

    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending frames, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
